// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared types and width helpers for the multi-channel SPI ADC
// reader and the sclk generator it shares with the DAC writer.
//   state_e    - controller state encoding
//   div_cnt_w  - width of a counter covering 0..CLK_DIV-1
//   edge_cnt_w - width of a counter covering 0..2*FRAME_BITS
package spi_adc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_DONE,
      S_QUIET
   } state_e;

   function automatic int div_cnt_w(input int clk_div);
      return (clk_div < 2) ? 1 : $clog2(clk_div);
   endfunction

   function automatic int edge_cnt_w(input int frame_bits);
      return $clog2(2 * frame_bits + 1);
   endfunction

endpackage

// File: rtl/spi_adc_multi_if.sv
// spi_adc_multi_if: request/result bus of the SPI ADC reader.
//   sample, cont_en        - requester -> reader (start / continuous mode)
//   ready, done, overrun   - reader status; done and overrun are 1-cycle pulses
//   dout                   - channel i at [i*DATA_W +: DATA_W]
interface spi_adc_multi_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 12
);
   logic                     sample;
   logic                     cont_en;
   logic                     ready;
   logic                     done;
   logic                     overrun;
   logic [NUM_CH*DATA_W-1:0] dout;

   modport master (output sample, cont_en, input ready, done, overrun, dout);
   modport slave  (input sample, cont_en, output ready, done, overrun, dout);
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: serial clock generator for SPI converters.
//   clk, reset_n - system clock, synchronous active-low reset
//   run          - while high, sclk toggles every CLK_DIV cycles, first toggle
//                  rising; while low, sclk is held low and counters clear
//   sclk         - registered serial clock
//   rise_stb     - high on the clk edge where sclk goes 0->1
//   fall_stb     - high on the clk edge where sclk goes 1->0
//   last_edge    - high on the edge carrying toggle number 2*FRAME_BITS
module spi_sclk_gen
   import spi_adc_pkg::*;
#(
   parameter int CLK_DIV    = 5,
   parameter int FRAME_BITS = 16
)(
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb,
   output logic last_edge
);
   localparam int DIV_W  = div_cnt_w(CLK_DIV);
   localparam int EDGE_W = edge_cnt_w(FRAME_BITS);

   logic [DIV_W-1:0]  div_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic              tick;

   assign tick      = run && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign rise_stb  = tick && !sclk;
   assign fall_stb  = tick &&  sclk;
   assign last_edge = tick && (edge_cnt == EDGE_W'(2 * FRAME_BITS - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || !run) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         sclk     <= 1'b0;
      end else if (tick) begin
         div_cnt  <= '0;
         sclk     <= ~sclk;
         edge_cnt <= last_edge ? '0 : edge_cnt + EDGE_W'(1);
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
      end
   end
endmodule

// File: rtl/spi_adc_multi.sv
// spi_adc_multi: reads NUM_CH SPI ADCs sharing cs_n/sclk, one data line each.
//   clk, reset_n - system clock, synchronous active-low reset
//   din          - serial data, bit i from ADC i
//   cs_n, sclk   - shared chip select (active low) and serial clock (idle low)
//   bus          - sample/cont_en in; ready/done/overrun/dout out
// Frame: SETUP (CLK_DIV cycles, sclk low), SHIFT (2*FRAME_BITS toggles of
// CLK_DIV cycles each), DONE (1 cycle, done pulse), QUIET (CLK_DIV cycles).
module spi_adc_multi
   import spi_adc_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 12,
   parameter int FRAME_BITS = 16,
   parameter int CLK_DIV    = 5
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] din,
   output logic              cs_n,
   output logic              sclk,
   spi_adc_multi_if.slave    bus
);
   localparam int DIV_W = div_cnt_w(CLK_DIV);

   state_e                         state;
   logic [DIV_W-1:0]               div_cnt;
   logic [NUM_CH-1:0][DATA_W-1:0]  shreg;
   logic [NUM_CH-1:0][DATA_W-1:0]  dout_q;
   logic                           ready_q, done_q, ovr_q;
   logic                           run, rise_stb, fall_stb, last_edge;

   assign run         = (state == S_SHIFT);
   assign bus.ready   = ready_q;
   assign bus.done    = done_q;
   assign bus.overrun = ovr_q;
   assign bus.dout    = dout_q;

   spi_sclk_gen #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_sclk (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (run),
      .sclk      (sclk),
      .rise_stb  (rise_stb),
      .fall_stb  (fall_stb),
      .last_edge (last_edge)
   );

   // Only the last DATA_W bits of a frame are kept, so a DATA_W-deep shifter
   // suffices: the leading FRAME_BITS-DATA_W bits fall off the top.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shreg <= '0;
      end else if (rise_stb) begin
         for (int i = 0; i < NUM_CH; i++)
            shreg[i] <= {shreg[i][DATA_W-2:0], din[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         div_cnt <= '0;
         cs_n    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         done_q <= 1'b0;
         // A request outside IDLE is dropped and flagged; a QUIET with
         // cont_en set restarts on its own, so sample there is not an error.
         ovr_q  <= bus.sample && (state != S_IDLE) &&
                   !((state == S_QUIET) && bus.cont_en);
         case (state)
            S_IDLE: begin
               if (bus.sample) begin
                  state   <= S_SETUP;
                  cs_n    <= 1'b0;
                  ready_q <= 1'b0;
                  div_cnt <= '0;
               end
            end
            S_SETUP: begin
               if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  state   <= S_SHIFT;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_SHIFT: begin
               // The final toggle is a fall, so sclk is low as cs_n rises.
               if (fall_stb && last_edge) begin
                  state  <= S_DONE;
                  cs_n   <= 1'b1;
                  done_q <= 1'b1;
                  dout_q <= shreg;
               end
            end
            S_DONE: begin
               state   <= S_QUIET;
               div_cnt <= '0;
            end
            S_QUIET: begin
               if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (bus.cont_en) begin
                     state <= S_SETUP;
                     cs_n  <= 1'b0;
                  end else begin
                     state   <= S_IDLE;
                     ready_q <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               cs_n    <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_adc_multi.sv
// tb_spi_adc_multi: scoreboard bench for spi_adc_multi at default parameters
// (dut_a) and at NUM_CH=4, DATA_W=10, FRAME_BITS=12, CLK_DIV=2 (dut_b).
// A small ADC model per DUT drives din MSB-first, advancing after each sclk rise.
module tb_spi_adc_multi;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT A: defaults ----------------
   logic [1:0]  din_a;
   logic        cs_n_a, sclk_a;
   logic [15:0] word_a [2];
   int          bc_a = 0;

   spi_adc_multi_if #(.NUM_CH(2), .DATA_W(12)) bus_a ();

   spi_adc_multi #(.NUM_CH(2), .DATA_W(12), .FRAME_BITS(16), .CLK_DIV(5)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din_a),
      .cs_n    (cs_n_a),
      .sclk    (sclk_a),
      .bus     (bus_a.slave)
   );

   always @(posedge sclk_a or posedge cs_n_a)
      if (cs_n_a) bc_a <= 0; else bc_a <= bc_a + 1;

   always_comb
      for (int i = 0; i < 2; i++)
         din_a[i] = (bc_a < 16) ? word_a[i][4'(15 - bc_a)] : 1'b0;

   // ---------------- DUT B: variant ----------------
   logic [3:0]  din_b;
   logic        cs_n_b, sclk_b;
   logic [11:0] word_b [4];
   int          bc_b = 0;

   spi_adc_multi_if #(.NUM_CH(4), .DATA_W(10)) bus_b ();

   spi_adc_multi #(.NUM_CH(4), .DATA_W(10), .FRAME_BITS(12), .CLK_DIV(2)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din_b),
      .cs_n    (cs_n_b),
      .sclk    (sclk_b),
      .bus     (bus_b.slave)
   );

   always @(posedge sclk_b or posedge cs_n_b)
      if (cs_n_b) bc_b <= 0; else bc_b <= bc_b + 1;

   always_comb
      for (int i = 0; i < 4; i++)
         din_b[i] = (bc_b < 12) ? word_b[i][4'(11 - bc_b)] : 1'b0;

   // ---------------- scoreboards and frame monitors ----------------
   logic [63:0] sb_a[$], sb_b[$];
   int done_cyc_a[$];
   int done_cnt_a = 0, done_cnt_b = 0, ovr_cnt_a = 0;
   int lo_a = 0, rs_a = 0, hi_a = 0, last_lo_a = 0, last_rs_a = 0, last_hi_a = 0;
   int lo_b = 0, rs_b = 0, last_lo_b = 0, last_rs_b = 0;
   logic cs_q_a = 1'b1, sclk_q_a = 1'b0, cs_q_b = 1'b1, sclk_q_b = 1'b0;

   always @(negedge clk) begin
      logic [63:0] e;
      if (bus_a.done === 1'b1) begin
         done_cnt_a++;
         done_cyc_a.push_back(cyc);
         checks++;
         if (sb_a.size() == 0) begin
            errors++;
            $display("FAIL sb_a: unexpected done, dout=%h", bus_a.dout);
         end else begin
            e = sb_a.pop_front();
            if (bus_a.dout !== e[23:0]) begin
               errors++;
               $display("FAIL sb_a dout: got %h expected %h", bus_a.dout, e[23:0]);
            end
         end
      end
      if (bus_b.done === 1'b1) begin
         done_cnt_b++;
         checks++;
         if (sb_b.size() == 0) begin
            errors++;
            $display("FAIL sb_b: unexpected done, dout=%h", bus_b.dout);
         end else begin
            e = sb_b.pop_front();
            if (bus_b.dout !== e[39:0]) begin
               errors++;
               $display("FAIL sb_b dout: got %h expected %h", bus_b.dout, e[39:0]);
            end
         end
      end
      if (bus_a.overrun === 1'b1) ovr_cnt_a++;
   end

   always @(negedge clk) begin
      if (cs_n_a === 1'b0) begin
         lo_a++;
         if (sclk_a && !sclk_q_a) rs_a++;
         if (cs_q_a) begin last_hi_a = hi_a; hi_a = 0; end
      end else begin
         hi_a++;
         if (!cs_q_a) begin last_lo_a = lo_a; last_rs_a = rs_a; lo_a = 0; rs_a = 0; end
      end
      cs_q_a = cs_n_a; sclk_q_a = sclk_a;
      if (cs_n_b === 1'b0) begin
         lo_b++;
         if (sclk_b && !sclk_q_b) rs_b++;
      end else if (!cs_q_b) begin
         last_lo_b = lo_b; last_rs_b = rs_b; lo_b = 0; rs_b = 0;
      end
      cs_q_b = cs_n_b; sclk_q_b = sclk_b;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start(input bit b);
      @(posedge clk); #1;
      if (b) bus_b.sample = 1'b1; else bus_a.sample = 1'b1;
      @(posedge clk); #1;
      bus_a.sample = 1'b0; bus_b.sample = 1'b0;
   endtask

   task automatic wait_done(input bit b, input int budget);
      int n0, k;
      n0 = b ? done_cnt_b : done_cnt_a;
      k  = 0;
      while (((b ? done_cnt_b : done_cnt_a) == n0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(b ? "done_b timeout" : "done_a timeout",
          64'(((b ? done_cnt_b : done_cnt_a) != n0)), 64'd1);
      #1;
   endtask

   task automatic set_a(input logic [15:0] c0, input logic [15:0] c1);
      word_a[0] = c0; word_a[1] = c1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n0, o0;
      bus_a.sample = 1'b0; bus_a.cont_en = 1'b0;
      bus_b.sample = 1'b0; bus_b.cont_en = 1'b0;
      set_a(16'h0, 16'h0);
      for (int i = 0; i < 4; i++) word_b[i] = 12'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst cs_n_a",   64'(cs_n_a), 64'd1);
      chk("rst sclk_a",   64'(sclk_a), 64'd0);
      chk("rst ready_a",  64'(bus_a.ready), 64'd1);
      chk("rst done_a",   64'(bus_a.done), 64'd0);
      chk("rst ovr_a",    64'(bus_a.overrun), 64'd0);
      chk("rst dout_a",   64'(bus_a.dout), 64'd0);
      chk("rst cs_n_b",   64'(cs_n_b), 64'd1);
      chk("rst dout_b",   64'(bus_b.dout), 64'd0);
      #1 reset_n = 1'b1;

      // single frame
      set_a(16'h0ABC, 16'h0123);
      sb_a.push_back(64'h123ABC);
      start(0);
      wait_done(0, 400);
      chk("f1 cs low clks", 64'(last_lo_a), 64'd165);
      chk("f1 sclk rises",  64'(last_rs_a), 64'd16);
      repeat (10) @(posedge clk);
      #1;
      chk("f1 ready",       64'(bus_a.ready), 64'd1);
      chk("f1 done count",  64'(done_cnt_a), 64'd1);

      // leading bits discarded
      set_a(16'hFABC, 16'h8FFF);
      sb_a.push_back(64'hFFFABC);
      start(0);
      wait_done(0, 400);
      repeat (10) @(posedge clk);

      // continuous mode, three frames, cont_en dropped during the third
      n0 = done_cnt_a;
      set_a(16'h1111, 16'h2222);
      sb_a.push_back(64'h222111);
      sb_a.push_back(64'hAAA555);
      sb_a.push_back(64'hFFF000);
      bus_a.cont_en = 1'b1;
      start(0);
      wait_done(0, 400);
      set_a(16'h0555, 16'hFAAA);
      wait_done(0, 400);
      set_a(16'h3000, 16'h0FFF);
      repeat (50) @(posedge clk);
      #1 bus_a.cont_en = 1'b0;
      wait_done(0, 400);
      chk("cont spacing 1-2", 64'(done_cyc_a[$-1] - done_cyc_a[$-2]), 64'd171);
      chk("cont spacing 2-3", 64'(done_cyc_a[$] - done_cyc_a[$-1]), 64'd171);
      chk("cont cs high gap", 64'(last_hi_a), 64'd6);
      repeat (20) @(posedge clk);
      #1;
      chk("cont ready",       64'(bus_a.ready), 64'd1);
      chk("cont cs_n idle",   64'(cs_n_a), 64'd1);
      chk("cont frames",      64'(done_cnt_a - n0), 64'd3);
      chk("cont no overrun",  64'(ovr_cnt_a), 64'd0);

      // overrun: sample pulsed mid-frame
      n0 = done_cnt_a; o0 = ovr_cnt_a;
      set_a(16'h0C3A, 16'h05A5);
      sb_a.push_back(64'h5A5C3A);
      start(0);
      repeat (48) @(posedge clk);
      #1 bus_a.sample = 1'b1;
      @(posedge clk);
      #1 bus_a.sample = 1'b0;
      wait_done(0, 400);
      repeat (200) @(posedge clk);
      #1;
      chk("ovr pulse cycles", 64'(ovr_cnt_a - o0), 64'd1);
      chk("ovr no extra",     64'(done_cnt_a - n0), 64'd1);
      chk("ovr ready",        64'(bus_a.ready), 64'd1);

      // reset mid-SHIFT
      n0 = done_cnt_a;
      set_a(16'h0F0F, 16'h00F0);
      start(0);
      repeat (78) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort cs_n",  64'(cs_n_a), 64'd1);
      chk("abort sclk",  64'(sclk_a), 64'd0);
      chk("abort dout",  64'(bus_a.dout), 64'd0);
      chk("abort ready", 64'(bus_a.ready), 64'd1);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("abort no done", 64'(done_cnt_a - n0), 64'd0);
      set_a(16'h0246, 16'h0357);
      sb_a.push_back(64'h357246);
      start(0);
      wait_done(0, 400);

      // variant instance
      word_b[0] = 12'hABC; word_b[1] = 12'h123; word_b[2] = 12'hFFF; word_b[3] = 12'h401;
      sb_b.push_back(64'({10'h001, 10'h3FF, 10'h123, 10'h2BC}));
      start(1);
      wait_done(1, 200);
      chk("b cs low clks", 64'(last_lo_b), 64'd50);
      chk("b sclk rises",  64'(last_rs_b), 64'd12);
      repeat (5) @(posedge clk);
      word_b[0] = 12'h555; word_b[1] = 12'hAAA; word_b[2] = 12'h000; word_b[3] = 12'h3C3;
      sb_b.push_back(64'({10'h3C3, 10'h000, 10'h2AA, 10'h155}));
      start(1);
      wait_done(1, 200);
      repeat (10) @(posedge clk);
      #1;
      chk("b ready",       64'(bus_b.ready), 64'd1);
      chk("b done count",  64'(done_cnt_b), 64'd2);

      chk("sb_a drained", 64'(sb_a.size()), 64'd0);
      chk("sb_b drained", 64'(sb_b.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
